// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: command codes, shift types,
// multiplier FSM states and NZCV bit positions.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second-operand selection: rotated immediate, memory offset, or shifted Rm.
module val2_generator
    import exe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH            = 32,
    parameter int unsigned SHIFTER_OPERAND_WIDTH = 12
) (
    input  logic [WORD_WIDTH-1:0]            val_Rm,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
    input  logic                             imm,
    input  logic                             mem_access,
    output logic [WORD_WIDTH-1:0]            val2
);

    function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x,
                                                   input logic [4:0] s);
        return (x >> s) | (x << (WORD_WIDTH - int'(s)));
    endfunction

    logic [4:0] shift_amt;
    logic [4:0] rot_amt;

    assign shift_amt = shifter_operand[11:7];
    assign rot_amt   = {shifter_operand[11:8], 1'b0};

    always_comb begin
        val2 = '0;
        if (imm) begin
            val2 = rotr(WORD_WIDTH'(shifter_operand[7:0]), rot_amt);
        end else if (mem_access) begin
            val2 = WORD_WIDTH'(shifter_operand);
        end else begin
            case (shifter_operand[6:5])
                SH_LSL:  val2 = val_Rm << shift_amt;
                SH_LSR:  val2 = val_Rm >> shift_amt;
                SH_ASR:  val2 = WORD_WIDTH'($signed(val_Rm) >>> shift_amt);
                default: val2 = rotr(val_Rm, shift_amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV register, branch target and optional iterative
// multiplier (compiled in when EXE_MUL_EN is defined).
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH            = 32,
    parameter int unsigned REG_FILE_DEPTH        = 4,
    parameter int unsigned SIGNED_IMM_WIDTH      = 24,
    parameter int unsigned SHIFTER_OPERAND_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [WORD_WIDTH-1:0]            pc_in,
    input  logic [WORD_WIDTH-1:0]            val_Rn_in,
    input  logic [WORD_WIDTH-1:0]            val_Rm_in,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
    input  logic [3:0]                       EX_command_in,
    input  logic                             Imm_in,
    input  logic                             B_in,
    input  logic                             SR_update_in,
    input  logic                             mem_read_in,
    input  logic                             mem_write_in,
    input  logic                             WB_en_in,
    input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
    output logic                             valid_out,
    output logic [WORD_WIDTH-1:0]            alu_result,
    output logic [WORD_WIDTH-1:0]            val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0]        reg_file_dst_out,
    output logic                             WB_en_out,
    output logic                             mem_read_out,
    output logic                             mem_write_out,
    output logic                             branch_taken,
    output logic [WORD_WIDTH-1:0]            branch_address,
    output logic [3:0]                       status_register,
    output logic                             stall
);

    localparam int unsigned SUM_W = WORD_WIDTH + 1;
    localparam int unsigned ACC_W = 2 * WORD_WIDTH;

    logic [WORD_WIDTH-1:0] val2;
    logic [SUM_W-1:0]      sum;
    logic [WORD_WIDTH-1:0] alu_res;
    logic                  alu_op;
    logic                  flag_c;
    logic                  flag_v;
    logic                  is_mul;
    logic [WORD_WIDTH-1:0] result;
    logic [3:0]            flags_nxt;
    logic                  flags_upd;
    logic                  wb_allow;

    assign is_mul = (EX_command_in == CMD_MUL);

    val2_generator #(
        .WORD_WIDTH            (WORD_WIDTH),
        .SHIFTER_OPERAND_WIDTH (SHIFTER_OPERAND_WIDTH)
    ) u_val2 (
        .val_Rm          (val_Rm_in),
        .shifter_operand (shifter_operand_in),
        .imm             (Imm_in),
        .mem_access      (mem_read_in | mem_write_in),
        .val2            (val2)
    );

    // Single-cycle ALU; C/V default to the held flags so logic ops retain them
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_op  = 1'b1;
        flag_c  = status_register[FLAG_C];
        flag_v  = status_register[FLAG_V];
        case (EX_command_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, val_Rn_in} + {1'b0, val2}
                    + SUM_W'((EX_command_in == CMD_ADC) && status_register[FLAG_C]);
                alu_res = sum[WORD_WIDTH-1:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (val_Rn_in[WORD_WIDTH-1] == val2[WORD_WIDTH-1])
                       && (alu_res[WORD_WIDTH-1] != val_Rn_in[WORD_WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                // Carry out of Rn + ~Val2 + cin is the ARM "not borrow"
                sum = {1'b0, val_Rn_in} + {1'b0, ~val2}
                    + SUM_W'((EX_command_in == CMD_SUB) || status_register[FLAG_C]);
                alu_res = sum[WORD_WIDTH-1:0];
                flag_c  = sum[WORD_WIDTH];
                flag_v  = (val_Rn_in[WORD_WIDTH-1] != val2[WORD_WIDTH-1])
                       && (alu_res[WORD_WIDTH-1] != val_Rn_in[WORD_WIDTH-1]);
            end
            CMD_AND: alu_res = val_Rn_in & val2;
            CMD_ORR: alu_res = val_Rn_in | val2;
            CMD_EOR: alu_res = val_Rn_in ^ val2;
            default: alu_op  = 1'b0;
        endcase
    end

`ifdef EXE_MUL_EN
    mul_state_e            mul_state;
    logic [4:0]            mul_cnt;
    logic [ACC_W-1:0]      mul_acc;
    logic [WORD_WIDTH-1:0] mul_a;
    logic [SUM_W-1:0]      mul_step;

    // Shift-add: multiplier sits in the low half and shifts out as product bits fill in
    assign mul_step = {1'b0, mul_acc[ACC_W-1:WORD_WIDTH]}
                    + (mul_acc[0] ? {1'b0, mul_a} : SUM_W'(0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_state <= IDLE;
            mul_cnt   <= '0;
            mul_acc   <= '0;
            mul_a     <= '0;
        end else begin
            case (mul_state)
                IDLE: begin
                    if (valid_in && is_mul) begin
                        mul_state <= BUSY;
                        mul_cnt   <= '0;
                        mul_acc   <= {{WORD_WIDTH{1'b0}}, val_Rm_in};
                        mul_a     <= val_Rn_in;
                    end
                end
                BUSY: begin
                    mul_acc <= {mul_step, mul_acc[WORD_WIDTH-1:1]};
                    mul_cnt <= mul_cnt + 5'd1;
                    if (mul_cnt == 5'd31) begin
                        mul_state <= DONE;
                    end
                end
                default: mul_state <= IDLE;
            endcase
        end
    end

    assign stall    = ((mul_state == IDLE) && valid_in && is_mul) || (mul_state == BUSY);
    assign wb_allow = 1'b1;

    always_comb begin
        result    = alu_res;
        flags_upd = alu_op;
        valid_out = valid_in && !stall;
        if (is_mul) begin
            result    = mul_acc[WORD_WIDTH-1:0];
            flags_upd = 1'b1;
            valid_out = (mul_state == DONE);
        end
    end
`else
    assign stall    = 1'b0;
    assign wb_allow = !is_mul;

    always_comb begin
        result    = alu_res;
        flags_upd = alu_op;
        valid_out = valid_in;
    end
`endif

    always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_N] = result[WORD_WIDTH-1];
        flags_nxt[FLAG_Z] = (result == '0);
        flags_nxt[FLAG_C] = flag_c;
        flags_nxt[FLAG_V] = flag_v;
    end

    // Branches never touch NZCV even with SR_update set
    always_ff @(posedge clk) begin
        if (!rst) begin
            status_register <= '0;
        end else if (valid_out && SR_update_in && flags_upd && !B_in) begin
            status_register <= flags_nxt;
        end
    end

    assign alu_result       = result;
    assign val_Rm_out       = val_Rm_in;
    assign reg_file_dst_out = reg_file_dst_in;
    assign WB_en_out        = WB_en_in && valid_out && wb_allow;
    assign mem_read_out     = mem_read_in && valid_out;
    assign mem_write_out    = mem_write_in && valid_out;
    assign branch_taken     = valid_in && B_in;
    assign branch_address   = pc_in + (WORD_WIDTH'({{(WORD_WIDTH - SIGNED_IMM_WIDTH){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                                                    signed_immediate_in}) << 2);

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; multiplier steps run only
// when EXE_MUL_EN is defined, otherwise MUL is checked as a NOP.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] val_Rn_in;
    logic [31:0] val_Rm_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shifter_operand_in;
    logic [3:0]  EX_command_in;
    logic        Imm_in;
    logic        B_in;
    logic        SR_update_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        WB_en_in;
    logic [3:0]  reg_file_dst_in;
    logic        valid_out;
    logic [31:0] alu_result;
    logic [31:0] val_Rm_out;
    logic [3:0]  reg_file_dst_out;
    logic        WB_en_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  status_register;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_in            (valid_in),
        .pc_in               (pc_in),
        .val_Rn_in           (val_Rn_in),
        .val_Rm_in           (val_Rm_in),
        .signed_immediate_in (signed_immediate_in),
        .shifter_operand_in  (shifter_operand_in),
        .EX_command_in       (EX_command_in),
        .Imm_in              (Imm_in),
        .B_in                (B_in),
        .SR_update_in        (SR_update_in),
        .mem_read_in         (mem_read_in),
        .mem_write_in        (mem_write_in),
        .WB_en_in            (WB_en_in),
        .reg_file_dst_in     (reg_file_dst_in),
        .valid_out           (valid_out),
        .alu_result          (alu_result),
        .val_Rm_out          (val_Rm_out),
        .reg_file_dst_out    (reg_file_dst_out),
        .WB_en_out           (WB_en_out),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .branch_taken        (branch_taken),
        .branch_address      (branch_address),
        .status_register     (status_register),
        .stall               (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in            = 1'b0;
        pc_in               = '0;
        val_Rn_in           = '0;
        val_Rm_in           = '0;
        signed_immediate_in = '0;
        shifter_operand_in  = '0;
        EX_command_in       = 4'b0000;
        Imm_in              = 1'b0;
        B_in                = 1'b0;
        SR_update_in        = 1'b0;
        mem_read_in         = 1'b0;
        mem_write_in        = 1'b0;
        WB_en_in            = 1'b0;
        reg_file_dst_in     = '0;
    endtask

    task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic [11:0] so, input logic imm, input logic sr);
        clear_inputs();
        valid_in           = 1'b1;
        EX_command_in      = cmd;
        val_Rn_in          = rn;
        val_Rm_in          = rm;
        shifter_operand_in = so;
        Imm_in             = imm;
        SR_update_in       = sr;
        WB_en_in           = 1'b1;
        reg_file_dst_in    = 4'd7;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("reset_status", 32'(status_register), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_valid_out", 32'(valid_out), 32'h0);
        check("reset_alu_result", alu_result, 32'h0);

        // ADD overflow into the sign bit
        alu_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 12'h000, 1'b0, 1'b1);
        #1;
        check("add_result", alu_result, 32'h8000_0000);
        check("add_valid_out", 32'(valid_out), 32'h1);
        check("add_wb_en", 32'(WB_en_out), 32'h1);
        check("add_dst", 32'(reg_file_dst_out), 32'h7);
        next_cycle();
        check("add_nzcv", 32'(status_register), 32'b1001);

        alu_op(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
        #1;
        check("sub_result", alu_result, 32'h0);
        next_cycle();
        check("sub_nzcv", 32'(status_register), 32'b0110);

        // ADC consumes C=1 from the SUB
        alu_op(4'b0011, 32'd1, 32'd1, 12'h000, 1'b0, 1'b1);
        #1;
        check("adc_result", alu_result, 32'd3);
        next_cycle();
        check("adc_nzcv", 32'(status_register), 32'b0000);

        alu_op(4'b0001, 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0);
        #1;
        check("mov_imm_rot", alu_result, 32'hFF00_0000);
        next_cycle();
        check("mov_no_sr_nzcv", 32'(status_register), 32'b0000);

        alu_op(4'b0001, 32'h0, 32'h8000_0000, 12'h240, 1'b0, 1'b0);
        #1;
        check("mov_asr4", alu_result, 32'hF800_0000);

        alu_op(4'b0110, 32'h0000_FFFF, 32'h0000_00FF, 12'h200, 1'b0, 1'b0);
        #1;
        check("and_lsl4", alu_result, 32'h0000_0FF0);

        alu_op(4'b0010, 32'h0000_1000, 32'h0000_DEAD, 12'hFFF, 1'b0, 1'b0);
        mem_read_in = 1'b1;
        #1;
        check("ldr_addr", alu_result, 32'h0000_1FFF);
        check("ldr_mem_read", 32'(mem_read_out), 32'h1);
        check("ldr_store_data", val_Rm_out, 32'h0000_DEAD);

        // Branch with SR_update and an ALU-looking command must not write flags
        alu_op(4'b0100, 32'h0, 32'h0, 12'h000, 1'b0, 1'b1);
        B_in                = 1'b1;
        pc_in               = 32'h0000_0100;
        signed_immediate_in = 24'hFF_FFFE;
        #1;
        check("branch_taken", 32'(branch_taken), 32'h1);
        check("branch_address", branch_address, 32'h0000_00F8);
        next_cycle();
        check("branch_nzcv", 32'(status_register), 32'b0000);

        clear_inputs();
        B_in     = 1'b1;
        WB_en_in = 1'b1;
        #1;
        check("branch_not_valid", 32'(branch_taken), 32'h0);
        check("wb_gated_by_valid", 32'(WB_en_out), 32'h0);

        alu_op(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
        next_cycle();
        // ORR updates N/Z and keeps C=1, V=0
        alu_op(4'b0111, 32'h8000_0000, 32'h0, 12'h000, 1'b0, 1'b1);
        next_cycle();
        check("orr_nzcv", 32'(status_register), 32'b1010);

        alu_op(4'b1111, 32'h1234, 32'h5678, 12'h000, 1'b0, 1'b1);
        #1;
        check("nop_result", alu_result, 32'h0);
        next_cycle();
        check("nop_nzcv", 32'(status_register), 32'b1010);

`ifdef EXE_MUL_EN
        alu_op(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
        next_cycle();
        check("pre_mul_nzcv", 32'(status_register), 32'b0110);

        alu_op(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 12'h000, 1'b0, 1'b1);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            next_cycle();
        end
        check("mul_stall_cycles", 32'(n), 32'd33);
        check("mul_valid_out", 32'(valid_out), 32'h1);
        check("mul_result", alu_result, 32'hFFFF_FFFF);
        check("mul_wb_en", 32'(WB_en_out), 32'h1);
        next_cycle();
        clear_inputs();
        #1;
        check("mul_nzcv", 32'(status_register), 32'b1010);
        check("mul_back_idle", 32'(stall), 32'h0);

        alu_op(4'b1010, 32'h3, 32'h5, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) next_cycle();
        check("mul_busy_stall", 32'(stall), 32'h1);
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        check("mulrst_stall", 32'(stall), 32'h0);
        check("mulrst_status", 32'(status_register), 32'h0);
        rst = 1'b1;
        alu_op(4'b0010, 32'd2, 32'd3, 12'h000, 1'b0, 1'b0);
        #1;
        check("mulrst_idle_add_valid", 32'(valid_out), 32'h1);
        check("mulrst_idle_add", alu_result, 32'd5);
`else
        alu_op(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 12'h000, 1'b0, 1'b1);
        #1;
        check("nomul_stall", 32'(stall), 32'h0);
        check("nomul_wb_en", 32'(WB_en_out), 32'h0);
        check("nomul_valid_out", 32'(valid_out), 32'h1);
        check("nomul_result", alu_result, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (stall) n++;
        end
        check("nomul_stall_never", 32'(n), 32'h0);
        check("nomul_nzcv", 32'(status_register), 32'b1010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
